// File: rtl/health_tracker_if.sv
// health_tracker_if: frame sync, battle gating, hit contacts, pixel
// position and the tracker's health/bar outputs, bundled between the
// game logic (master) and the health tracker (slave).
interface health_tracker_if;
    logic       frame_clk;
    logic       battle_l;
    logic       Player_Hit;
    logic       NPC_Hit;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] Player_HP;
    logic [7:0] NPC_HP;
    logic       Player_Dead;
    logic       NPC_Dead;
    logic       is_player_bar;
    logic       is_npc_bar;

    modport slave (
        input  frame_clk, battle_l, Player_Hit, NPC_Hit, DrawX, DrawY,
        output Player_HP, NPC_HP, Player_Dead, NPC_Dead,
               is_player_bar, is_npc_bar
    );

    modport master (
        output frame_clk, battle_l, Player_Hit, NPC_Hit, DrawX, DrawY,
        input  Player_HP, NPC_HP, Player_Dead, NPC_Dead,
               is_player_bar, is_npc_bar
    );
endinterface

// File: rtl/health_tracker.sv
// health_tracker: hit-point tracker for the player and the NPC with a
// per-character invincibility window counted in video frames, sticky
// death flags and health-bar pixel flags.
// Optional feature: define HEALTH_REGEN_EN to enable slow regeneration
// (one HP every REGEN_FRAMES frames while vulnerable in battle).
module health_tracker #(
    parameter int         MAX_HP       = 100,
    parameter int         HIT_DMG      = 10,
    parameter int         IFRAMES      = 30,
    parameter int         REGEN_FRAMES = 60,
    parameter logic [9:0] BAR_Y        = 10'd20
) (
    input  logic              Clk,
    input  logic              Reset,
    health_tracker_if.slave   bus
);

    localparam logic [7:0] MAX8   = 8'(MAX_HP);
    localparam logic [7:0] DMG8   = 8'(HIT_DMG);
    localparam logic [5:0] IFR6   = 6'(IFRAMES);
`ifdef HEALTH_REGEN_EN
    localparam logic [5:0] REGEN6 = 6'(REGEN_FRAMES);
`endif

    // Per-character state; rcnt is the regeneration frame counter and
    // stays at zero when regeneration is compiled out.
    typedef struct packed {
        logic [7:0] hp;
        logic       dead;
        logic [5:0] ifr;
        logic [5:0] rcnt;
    } chr_t;

    localparam chr_t CHR_RST = '{hp: MAX8, dead: 1'b0, ifr: 6'd0, rcnt: 6'd0};

    // Next state of one character given its hit edge, battle gate and tick.
    function automatic chr_t chr_next(input chr_t cur, input logic hit,
                                      input logic battle, input logic tick);
        chr_t nxt;
        nxt = cur;
        if (cur.dead) begin
            // Absorbing: only reset leaves this state.
            nxt.hp   = 8'd0;
            nxt.dead = 1'b1;
            nxt.rcnt = 6'd0;
            if (tick && (cur.ifr != 6'd0)) begin
                nxt.ifr = cur.ifr - 6'd1;
            end else begin
                nxt.ifr = cur.ifr;
            end
        end else if (hit && battle && (cur.ifr == 6'd0)) begin
            // Accepted hit wins over a same-cycle frame tick.
            nxt.hp   = (cur.hp > DMG8) ? (cur.hp - DMG8) : 8'd0;
            nxt.ifr  = IFR6;
            nxt.rcnt = 6'd0;
            nxt.dead = (nxt.hp == 8'd0);
        end else begin
            // Invincibility keeps counting down even outside battle.
            if (tick && (cur.ifr != 6'd0)) begin
                nxt.ifr = cur.ifr - 6'd1;
            end else begin
                nxt.ifr = cur.ifr;
            end
`ifdef HEALTH_REGEN_EN
            if (tick && battle && (cur.ifr == 6'd0)) begin
                if ((cur.rcnt + 6'd1) == REGEN6) begin
                    nxt.rcnt = 6'd0;
                    nxt.hp   = (cur.hp < MAX8) ? (cur.hp + 8'd1) : MAX8;
                end else begin
                    nxt.rcnt = cur.rcnt + 6'd1;
                end
            end else begin
                nxt.rcnt = cur.rcnt;
            end
`else
            nxt.rcnt = 6'd0;
`endif
        end
        return nxt;
    endfunction

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic fprev_q, fprev_d;
    logic tick_q,  tick_d;
    logic phit_q,  phit_d;
    logic pprev_q, pprev_d;
    logic nhit_q,  nhit_d;
    logic nprev_q, nprev_d;
    chr_t ply_q,   ply_d;
    chr_t npc_q,   npc_d;
    logic p_edge_s, n_edge_s;

    // Next-state logic: vsync resync + edge detect, hit edges, character updates.
    always_comb begin
        sync1_d  = bus.frame_clk;
        sync2_d  = sync1_q;
        fprev_d  = sync2_q;
        tick_d   = sync2_q & ~fprev_q;
        phit_d   = bus.Player_Hit;
        pprev_d  = phit_q;
        nhit_d   = bus.NPC_Hit;
        nprev_d  = nhit_q;
        p_edge_s = phit_q & ~pprev_q;
        n_edge_s = nhit_q & ~nprev_q;
        ply_d    = chr_next(ply_q, p_edge_s, bus.battle_l, tick_q);
        npc_d    = chr_next(npc_q, n_edge_s, bus.battle_l, tick_q);
    end

    // State registers; synchronous reset has priority over every event.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fprev_q <= 1'b0;
            tick_q  <= 1'b0;
            phit_q  <= 1'b0;
            pprev_q <= 1'b0;
            nhit_q  <= 1'b0;
            nprev_q <= 1'b0;
            ply_q   <= CHR_RST;
            npc_q   <= CHR_RST;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            fprev_q <= fprev_d;
            tick_q  <= tick_d;
            phit_q  <= phit_d;
            pprev_q <= pprev_d;
            nhit_q  <= nhit_d;
            nprev_q <= nprev_d;
            ply_q   <= ply_d;
            npc_q   <= npc_d;
        end
    end

    assign bus.Player_HP   = ply_q.hp;
    assign bus.NPC_HP      = npc_q.hp;
    assign bus.Player_Dead = ply_q.dead;
    assign bus.NPC_Dead    = npc_q.dead;

    logic       row_s;
    logic [9:0] p_len_s, n_len_s;

    // Bar pixel flags: player bar grows right from x=20, NPC bar grows left from x=620.
    always_comb begin
        p_len_s = {1'b0, ply_q.hp, 1'b0};
        n_len_s = {1'b0, npc_q.hp, 1'b0};
        row_s   = (bus.DrawY >= BAR_Y) && (bus.DrawY < (BAR_Y + 10'd10));
        bus.is_player_bar = row_s && (bus.DrawX >= 10'd20)
                            && (bus.DrawX < (10'd20 + p_len_s));
        bus.is_npc_bar    = row_s && (bus.DrawX >= (10'd620 - n_len_s))
                            && (bus.DrawX < 10'd620);
    end

endmodule

// File: tb/tb_health_tracker.sv
// tb_health_tracker: directed test of health_tracker (default build and a
// MAX_HP=25 instance); regeneration checks run when HEALTH_REGEN_EN is defined.
module tb_health_tracker;
    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;

    health_tracker_if bus0 ();
    health_tracker_if bus1 ();

    health_tracker u_dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0.slave));
    health_tracker #(.MAX_HP(25)) u_dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1.slave));

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cyc(2);
        Reset = 1'b0;
        cyc(6);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus0.frame_clk = 1'b0;
            bus1.frame_clk = 1'b0;
            cyc(3);
            bus0.frame_clk = 1'b1;
            bus1.frame_clk = 1'b1;
            cyc(6);
        end
    endtask

    task automatic hit_player0();
        bus0.Player_Hit = 1'b1;
        cyc(1);
        bus0.Player_Hit = 1'b0;
        cyc(3);
    endtask

    task automatic hit_npc0();
        bus0.NPC_Hit = 1'b1;
        cyc(1);
        bus0.NPC_Hit = 1'b0;
        cyc(3);
    endtask

    task automatic hit_npc1();
        bus1.NPC_Hit = 1'b1;
        cyc(1);
        bus1.NPC_Hit = 1'b0;
        cyc(3);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b1;
        bus0.frame_clk = 1'b1; bus0.battle_l = 1'b0;
        bus0.Player_Hit = 1'b0; bus0.NPC_Hit = 1'b0;
        bus0.DrawX = 10'd0; bus0.DrawY = 10'd0;
        bus1.frame_clk = 1'b1; bus1.battle_l = 1'b0;
        bus1.Player_Hit = 1'b0; bus1.NPC_Hit = 1'b0;
        bus1.DrawX = 10'd0; bus1.DrawY = 10'd0;

        // Reset state
        do_reset();
        check_eq("rst_php", 32'(bus0.Player_HP), 32'd100);
        check_eq("rst_nhp", 32'(bus0.NPC_HP), 32'd100);
        check_eq("rst_pdead", 32'(bus0.Player_Dead), 32'd0);
        check_eq("rst_ndead", 32'(bus0.NPC_Dead), 32'd0);
        check_eq("rst_hp25", 32'(bus1.NPC_HP), 32'd25);

        // Bar geometry at hp=100
        bus0.DrawY = 10'd25; bus0.DrawX = 10'd219; #1;
        check_eq("pbar_219", 32'(bus0.is_player_bar), 32'd1);
        bus0.DrawX = 10'd220; #1;
        check_eq("pbar_220", 32'(bus0.is_player_bar), 32'd0);
        bus0.DrawX = 10'd19; #1;
        check_eq("pbar_19", 32'(bus0.is_player_bar), 32'd0);
        bus0.DrawX = 10'd420; #1;
        check_eq("nbar_420", 32'(bus0.is_npc_bar), 32'd1);
        bus0.DrawX = 10'd419; #1;
        check_eq("nbar_419", 32'(bus0.is_npc_bar), 32'd0);
        bus0.DrawX = 10'd620; #1;
        check_eq("nbar_620", 32'(bus0.is_npc_bar), 32'd0);
        bus0.DrawY = 10'd30; bus0.DrawX = 10'd100; #1;
        check_eq("pbar_row30", 32'(bus0.is_player_bar), 32'd0);
        bus0.DrawY = 10'd29; #1;
        check_eq("pbar_row29", 32'(bus0.is_player_bar), 32'd1);

        // Single NPC hit: latency, then held level counts once
        bus0.battle_l = 1'b1;
        bus0.NPC_Hit = 1'b1;
        cyc(1);
        check_eq("nhit_lat1", 32'(bus0.NPC_HP), 32'd100);
        cyc(1);
        check_eq("nhit_90", 32'(bus0.NPC_HP), 32'd90);
        cyc(500);
        check_eq("nhit_held", 32'(bus0.NPC_HP), 32'd90);
        bus0.NPC_Hit = 1'b0;
        cyc(3);
        bus0.DrawY = 10'd25; bus0.DrawX = 10'd439; #1;
        check_eq("nbar_439", 32'(bus0.is_npc_bar), 32'd0);
        bus0.DrawX = 10'd440; #1;
        check_eq("nbar_440", 32'(bus0.is_npc_bar), 32'd1);

        // Invincibility window on the player
        hit_player0();
        check_eq("inv_t0", 32'(bus0.Player_HP), 32'd90);
        frames(29);
        hit_player0();
        check_eq("inv_29", 32'(bus0.Player_HP), 32'd90);
        frames(1);
        hit_player0();
        check_eq("inv_30", 32'(bus0.Player_HP), 32'd80);
        check_eq("inv_alive", 32'(bus0.Player_Dead), 32'd0);

        // Simultaneous hits and battle gating
        do_reset();
        check_eq("rst2_php", 32'(bus0.Player_HP), 32'd100);
        bus0.Player_Hit = 1'b1;
        bus0.NPC_Hit = 1'b1;
        cyc(2);
        check_eq("sim_php", 32'(bus0.Player_HP), 32'd90);
        check_eq("sim_nhp", 32'(bus0.NPC_HP), 32'd90);
        bus0.Player_Hit = 1'b0;
        bus0.NPC_Hit = 1'b0;
        cyc(3);
        bus0.battle_l = 1'b0;
        frames(31);
        hit_npc0();
        check_eq("gate_off", 32'(bus0.NPC_HP), 32'd90);
        bus0.battle_l = 1'b1;
        hit_npc0();
        check_eq("gate_on", 32'(bus0.NPC_HP), 32'd80);

        // Saturating kill on the MAX_HP=25 instance
        check_eq("k_start", 32'(bus1.NPC_HP), 32'd25);
        bus1.battle_l = 1'b1;
        hit_npc1();
        check_eq("k_hp15", 32'(bus1.NPC_HP), 32'd15);
        frames(31);
        hit_npc1();
        check_eq("k_hp5", 32'(bus1.NPC_HP), 32'd5);
        check_eq("k_alive", 32'(bus1.NPC_Dead), 32'd0);
        frames(31);
        hit_npc1();
        check_eq("k_hp0", 32'(bus1.NPC_HP), 32'd0);
        check_eq("k_dead", 32'(bus1.NPC_Dead), 32'd1);
        frames(31);
        hit_npc1();
        check_eq("k_hp0_again", 32'(bus1.NPC_HP), 32'd0);
        check_eq("k_dead_sticky", 32'(bus1.NPC_Dead), 32'd1);
        bus1.DrawY = 10'd25; bus1.DrawX = 10'd619; #1;
        check_eq("k_nbar_empty", 32'(bus1.is_npc_bar), 32'd0);
        do_reset();
        check_eq("k_rst_hp", 32'(bus1.NPC_HP), 32'd25);
        check_eq("k_rst_dead", 32'(bus1.NPC_Dead), 32'd0);

`ifdef HEALTH_REGEN_EN
        // Regeneration: 30 invincible frames, then 60 vulnerable frames per HP
        bus0.battle_l = 1'b1;
        hit_player0();
        check_eq("rg_hit", 32'(bus0.Player_HP), 32'd90);
        frames(89);
        check_eq("rg_89", 32'(bus0.Player_HP), 32'd90);
        frames(1);
        check_eq("rg_91", 32'(bus0.Player_HP), 32'd91);
        frames(600);
        check_eq("rg_100", 32'(bus0.Player_HP), 32'd100);
        frames(60);
        check_eq("rg_cap", 32'(bus0.Player_HP), 32'd100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
